// File: rtl/axi_rd_req_arbiter.sv
// rtl/axi_rd_req_arbiter.sv - round-robin sharing of one AXI4 read channel (AR + R) among NUM_REQ requesters
//
// Ports:
//   MASTER_CLK / MASTER_RSTN     clock, synchronous active-low reset
//   REQ_ADDR/LEN/BURST/VALID     per-requester read commands (requester i in slice i)
//   REQ_READY                    one-hot command accept
//   REQ_RD_DATA/RESP/LAST        shared read beat payload
//   REQ_RD_VALID / REQ_RD_READY  per-requester beat handshake, selected by RID
//   MASTER_RD_ADDR_*             AR channel toward the interconnect, ARID = requester index
//   MASTER_RD_BACK_ID, *_DATA_*  R channel from the interconnect
//   ERR_FLAG                     sticky: unknown RID or RLAST with nothing outstanding
module axi_rd_req_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ID_WIDTH        = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    MASTER_CLK,
    input  logic                    MASTER_RSTN,
    input  logic [32*NUM_REQ-1:0]   REQ_ADDR,
    input  logic [8*NUM_REQ-1:0]    REQ_LEN,
    input  logic [2*NUM_REQ-1:0]    REQ_BURST,
    input  logic [NUM_REQ-1:0]      REQ_VALID,
    output logic [NUM_REQ-1:0]      REQ_READY,
    output logic [31:0]             REQ_RD_DATA,
    output logic [1:0]              REQ_RD_RESP,
    output logic                    REQ_RD_LAST,
    output logic [NUM_REQ-1:0]      REQ_RD_VALID,
    input  logic [NUM_REQ-1:0]      REQ_RD_READY,
    output logic [ID_WIDTH-1:0]     MASTER_RD_ADDR_ID,
    output logic [31:0]             MASTER_RD_ADDR,
    output logic [7:0]              MASTER_RD_ADDR_LEN,
    output logic [1:0]              MASTER_RD_ADDR_BURST,
    output logic                    MASTER_RD_ADDR_VALID,
    input  logic                    MASTER_RD_ADDR_READY,
    input  logic [ID_WIDTH-1:0]     MASTER_RD_BACK_ID,
    input  logic [31:0]             MASTER_RD_DATA,
    input  logic [1:0]              MASTER_RD_DATA_RESP,
    input  logic                    MASTER_RD_DATA_LAST,
    input  logic                    MASTER_RD_DATA_VALID,
    output logic                    MASTER_RD_DATA_READY,
    output logic                    ERR_FLAG
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [PTR_W-1:0]    r_grant;
    logic [CNT_W-1:0]    r_cnt [NUM_REQ];
    logic [ID_WIDTH-1:0] r_arid;
    logic [31:0]         r_araddr;
    logic [7:0]          r_arlen;
    logic [1:0]          r_arburst;
    logic                r_arvalid;
    logic                r_err;

    logic [NUM_REQ-1:0]  w_elig;
    logic                w_found;
    logic [PTR_W-1:0]    w_winner;
    logic [NUM_REQ-1:0]  w_rd_sel;
    logic                w_rid_ok;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic [NUM_REQ-1:0]  w_inc;
    logic [NUM_REQ-1:0]  w_dec;
    logic [NUM_REQ-1:0]  w_underflow;

    // A requester may compete only while it has room for another burst.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = REQ_VALID[i] && (r_cnt[i] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    // Scan downward so the candidate closest to r_rr_ptr is the last to overwrite.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (w_elig[idx]) begin
                w_found  = 1'b1;
                w_winner = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        REQ_READY = '0;
        if (MASTER_RSTN && (r_state == S_IDLE) && w_found) begin
            REQ_READY[w_winner] = 1'b1;
        end
    end

    always_comb begin
        w_rd_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rd_sel[i] = (MASTER_RD_BACK_ID == ID_WIDTH'(i));
        end
    end

    assign w_rid_ok     = |w_rd_sel;
    assign REQ_RD_VALID = w_rd_sel & {NUM_REQ{MASTER_RD_DATA_VALID}};
    assign REQ_RD_DATA  = MASTER_RD_DATA;
    assign REQ_RD_RESP  = MASTER_RD_DATA_RESP;
    assign REQ_RD_LAST  = MASTER_RD_DATA_LAST;
    // Beats with an unknown RID are drained so the interconnect never stalls on them.
    assign MASTER_RD_DATA_READY = MASTER_RSTN && (w_rid_ok ? |(w_rd_sel & REQ_RD_READY) : 1'b1);

    assign w_ar_hs = r_arvalid && MASTER_RD_ADDR_READY;
    assign w_r_hs  = MASTER_RD_DATA_VALID && MASTER_RD_DATA_READY;

    always_comb begin
        w_inc       = '0;
        w_dec       = '0;
        w_underflow = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_inc[i]       = w_ar_hs && (r_grant == PTR_W'(i));
            w_dec[i]       = w_r_hs && MASTER_RD_DATA_LAST && w_rd_sel[i];
            // A simultaneous issue cancels the retire, so only a lone retire can underflow.
            w_underflow[i] = w_dec[i] && !w_inc[i] && (r_cnt[i] == '0);
        end
    end

    always_ff @(posedge MASTER_CLK) begin
        if (!MASTER_RSTN) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arburst <= '0;
            r_arvalid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant   <= w_winner;
                        r_arid    <= ID_WIDTH'(w_winner);
                        r_araddr  <= REQ_ADDR[32*w_winner +: 32];
                        r_arlen   <= REQ_LEN[8*w_winner +: 8];
                        r_arburst <= REQ_BURST[2*w_winner +: 2];
                        r_arvalid <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (MASTER_RD_ADDR_READY) begin
                        r_arvalid <= 1'b0;
                        r_rr_ptr  <= (r_grant == PTR_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge MASTER_CLK) begin
        if (!MASTER_RSTN) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_cnt[i] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_inc[i] && !w_dec[i] && (r_cnt[i] != CNT_W'(MAX_OUTSTANDING))) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
            if ((w_r_hs && !w_rid_ok) || (|w_underflow)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign MASTER_RD_ADDR_ID    = r_arid;
    assign MASTER_RD_ADDR       = r_araddr;
    assign MASTER_RD_ADDR_LEN   = r_arlen;
    assign MASTER_RD_ADDR_BURST = r_arburst;
    assign MASTER_RD_ADDR_VALID = r_arvalid;
    assign ERR_FLAG             = r_err;

endmodule

// File: tb/tb_axi_rd_req_arbiter.sv
// tb/tb_axi_rd_req_arbiter.sv - randomized check of axi_rd_req_arbiter against a queue-based reference model
module tb_axi_rd_req_arbiter;

    localparam int NR  = 2;
    localparam int IDW = 2;
    localparam int MO  = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic [32*NR-1:0]  req_addr;
    logic [8*NR-1:0]   req_len;
    logic [2*NR-1:0]   req_burst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [31:0]       rd_data;
    logic [1:0]        rd_resp;
    logic              rd_last;
    logic [NR-1:0]     rd_valid;
    logic [NR-1:0]     rd_ready;
    logic [IDW-1:0]    ar_id;
    logic [31:0]       ar_addr;
    logic [7:0]        ar_len;
    logic [1:0]        ar_burst;
    logic              ar_valid;
    logic              ar_ready;
    logic [IDW-1:0]    r_id;
    logic [31:0]       r_data;
    logic [1:0]        r_resp;
    logic              r_last;
    logic              r_valid;
    logic              r_ready;
    logic              err_flag;

    always #5 clk = ~clk;

    axi_rd_req_arbiter #(.NUM_REQ(NR), .ID_WIDTH(IDW), .MAX_OUTSTANDING(MO)) dut (
        .MASTER_CLK(clk), .MASTER_RSTN(rstn),
        .REQ_ADDR(req_addr), .REQ_LEN(req_len), .REQ_BURST(req_burst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_RD_DATA(rd_data), .REQ_RD_RESP(rd_resp), .REQ_RD_LAST(rd_last),
        .REQ_RD_VALID(rd_valid), .REQ_RD_READY(rd_ready),
        .MASTER_RD_ADDR_ID(ar_id), .MASTER_RD_ADDR(ar_addr), .MASTER_RD_ADDR_LEN(ar_len),
        .MASTER_RD_ADDR_BURST(ar_burst), .MASTER_RD_ADDR_VALID(ar_valid),
        .MASTER_RD_ADDR_READY(ar_ready),
        .MASTER_RD_BACK_ID(r_id), .MASTER_RD_DATA(r_data), .MASTER_RD_DATA_RESP(r_resp),
        .MASTER_RD_DATA_LAST(r_last), .MASTER_RD_DATA_VALID(r_valid),
        .MASTER_RD_DATA_READY(r_ready), .ERR_FLAG(err_flag)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: outstanding bursts per requester, a pending-command slot and the RR start point.
    int          m_cnt [NR];
    int          m_rr;
    bit          m_busy;
    int          m_id;
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    logic [1:0]  m_burst;
    bit          m_err;

    // Slave side: per-ID list of beats remaining in each accepted burst, oldest first.
    int          sq [4][$];
    bit          cur_v;
    int          cur_id;
    logic [31:0] cur_data;
    logic [1:0]  cur_resp;
    bit          cur_bad_last;

    // Stimulus knobs (percent probabilities).
    int k_req, k_ar, k_r, k_rdy;
    bit k_rst, k_bad;

    task automatic cycle();
        int          grant;
        int          pick [$];
        bit          exp_last;
        bit          exp_rready;
        logic [NR-1:0] exp_rvalid;
        logic [NR-1:0] exp_ready;
        bit          ar_hs, r_hs;
        bit          inc, dec;

        rstn = !k_rst;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = ($urandom_range(99) < k_req);
            req_addr[32*i +: 32]  = $urandom & 32'hFFFF_FFFC;
            req_len[8*i +: 8]     = 8'($urandom_range(0, 7));
            req_burst[2*i +: 2]   = 2'($urandom_range(0, 3));
            rd_ready[i]           = ($urandom_range(99) < k_rdy);
        end
        ar_ready = k_rst ? 1'b0 : ($urandom_range(99) < k_ar);

        if (!cur_v) begin
            pick.delete();
            for (int i = 0; i < NR; i++) if (sq[i].size() > 0) pick.push_back(i);
            if (k_bad && ($urandom_range(99) < 30)) begin
                cur_v        = 1'b1;
                cur_id       = 3;
                cur_bad_last = 1'($urandom_range(0, 1));
            end else if ((pick.size() > 0) && ($urandom_range(99) < k_r)) begin
                cur_v  = 1'b1;
                cur_id = pick[$urandom_range(0, pick.size() - 1)];
            end
            cur_data = $urandom;
            cur_resp = 2'($urandom_range(0, 3));
        end
        exp_last = (cur_id < NR) ? (cur_v && sq[cur_id].size() > 0 && sq[cur_id][0] == 1) : cur_bad_last;
        r_valid = cur_v;
        r_id    = IDW'(cur_id);
        r_data  = cur_data;
        r_resp  = cur_resp;
        r_last  = exp_last;

        grant = -1;
        if (!k_rst && !m_busy) begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_rr + k) % NR;
                if (grant < 0 && req_valid[i] && m_cnt[i] < MO) grant = i;
            end
        end
        exp_ready = '0;
        if (grant >= 0) exp_ready[grant] = 1'b1;
        exp_rvalid = '0;
        if (cur_id < NR) begin
            exp_rvalid[cur_id] = cur_v;
            exp_rready = !k_rst && rd_ready[cur_id];
        end else begin
            exp_rready = !k_rst;
        end

        #3;
        check("req_ready", req_ready, exp_ready);
        check("arvalid", ar_valid, m_busy);
        if (m_busy) begin
            check("arid", ar_id, m_id);
            check("araddr", ar_addr, m_addr);
            check("arlen", ar_len, m_len);
            check("arburst", ar_burst, m_burst);
        end
        check("rready", r_ready, exp_rready);
        check("rd_valid", rd_valid, exp_rvalid);
        if (cur_v && cur_id < NR) begin
            check("rd_data", rd_data, cur_data);
            check("rd_resp", rd_resp, cur_resp);
            check("rd_last", rd_last, exp_last);
        end
        check("err_flag", err_flag, m_err);

        @(posedge clk);
        if (k_rst) begin
            for (int i = 0; i < NR; i++) m_cnt[i] = 0;
            m_rr   = 0;
            m_busy = 1'b0;
            m_err  = 1'b0;
        end else begin
            ar_hs = m_busy && ar_ready;
            r_hs  = cur_v && exp_rready;
            for (int i = 0; i < NR; i++) begin
                inc = ar_hs && (m_id == i);
                dec = r_hs && (cur_id == i) && exp_last;
                if (inc && !dec) m_cnt[i]++;
                else if (dec && !inc) begin
                    if (m_cnt[i] == 0) m_err = 1'b1;
                    else m_cnt[i]--;
                end
            end
            if (r_hs) begin
                if (cur_id >= NR) m_err = 1'b1;
                else begin
                    sq[cur_id][0] = sq[cur_id][0] - 1;
                    if (sq[cur_id][0] == 0) void'(sq[cur_id].pop_front());
                end
                cur_v = 1'b0;
            end
            if (ar_hs) begin
                sq[m_id].push_back(int'(m_len) + 1);
                m_busy = 1'b0;
                m_rr   = (m_id + 1) % NR;
            end else if (grant >= 0) begin
                m_busy  = 1'b1;
                m_id    = grant;
                m_addr  = req_addr[32*grant +: 32];
                m_len   = req_len[8*grant +: 8];
                m_burst = req_burst[2*grant +: 2];
            end
        end
        #1;
    endtask

    task automatic phase(input int n, input int rq, input int ar, input int r, input int rdy,
                         input bit rst, input bit bad);
        k_req = rq; k_ar = ar; k_r = r; k_rdy = rdy; k_rst = rst; k_bad = bad;
        for (int c = 0; c < n; c++) cycle();
    endtask

    initial begin
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        m_rr = 0; m_busy = 0; m_id = 0; m_addr = '0; m_len = '0; m_burst = '0; m_err = 0;
        cur_v = 0; cur_id = 0; cur_data = '0; cur_resp = '0; cur_bad_last = 0;
        rstn = 1'b0; req_valid = '0; req_addr = '0; req_len = '0; req_burst = '0;
        rd_ready = '0; ar_ready = 1'b0; r_valid = 1'b0; r_id = '0; r_data = '0;
        r_resp = '0; r_last = 1'b0;
        @(posedge clk); #1;

        phase(3,   50,  50,   0,  50, 1, 0);   // reset state
        phase(400, 60,  70,  50,  70, 0, 0);   // mixed traffic
        phase(40,  100, 100,  0, 100, 0, 0);   // fill to the outstanding limit
        phase(12,  100,   0,  0, 100, 0, 0);   // AR stalled, fields held
        phase(150, 0,   100, 100, 100, 0, 0);  // drain
        phase(200, 70,  60,  60,  40, 0, 0);   // back-pressured returns
        phase(20,  100, 100,  0, 100, 0, 0);   // fill again
        phase(2,   50,  50,  50,  50, 1, 0);   // reset with bursts in flight
        phase(150, 0,   100, 100, 100, 0, 0);  // stale beats drain, RLAST flags error
        phase(3,   50,  50,   0,  50, 1, 0);   // reset clears the flag
        phase(200, 60,  70,  50,  70, 0, 1);   // unknown RID beats mixed in
        phase(3,   50,  50,   0,  50, 1, 0);
        phase(60,  60,  70,  50,  70, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
